// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-cache memory bus: op codes, default widths and arbiter states.
// Used by the cache controllers and by the arbiter itself.
package mem_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDRWIDTH = 16;
    localparam int unsigned DEF_WORDWIDTH = 16;

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_WT   = 2'd1;
    localparam logic [1:0] OP_IDEL = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    // 2'd3 is reserved and behaves like IDEL.
    function automatic logic is_req(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_WT);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts BUSY cycles of the arbiter and flags the cycle in which the TIMEOUT-th one is reached.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count_q, count_d;

    assign expire = enable && (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting two caches access to one shared memory port, with a
// per-transaction watchdog. All outputs are registered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int unsigned WORDWIDTH = DEF_WORDWIDTH,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           rw0,
    input  logic [1:0]           rw1,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [WORDWIDTH-1:0] data0,
    input  logic [WORDWIDTH-1:0] data1,
    output logic                 readEn0,
    output logic                 readEn1,
    output logic                 writeDone0,
    output logic                 writeDone1,
    output logic [WORDWIDTH-1:0] dataToCache,
    output logic [ADDRWIDTH-1:0] addrToCache,
    output logic [1:0]           memRw,
    output logic [ADDRWIDTH-1:0] memAddr,
    output logic [WORDWIDTH-1:0] memData,
    input  logic [WORDWIDTH-1:0] memRdData,
    input  logic                 memRdValid,
    input  logic                 memWtDone,
    output logic [1:0]           grant,
    output logic                 busErr
);

    arb_state_e state_q, state_d;

    logic                 ptr_q, ptr_d;
    logic                 owner_q, owner_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           mem_rw_q, mem_rw_d;
    logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORDWIDTH-1:0] mem_data_q, mem_data_d;
    logic [WORDWIDTH-1:0] data_to_cache_q, data_to_cache_d;
    logic [ADDRWIDTH-1:0] addr_to_cache_q, addr_to_cache_d;
    logic [1:0]           read_en_q, read_en_d;
    logic [1:0]           write_done_q, write_done_d;
    logic                 bus_err_q, bus_err_d;

    logic pend0, pend1, sel_valid, sel_idx;
    logic rd_done, wt_done, complete, expire;

    assign pend0     = (state_q == StIdle) && is_req(rw0);
    assign pend1     = (state_q == StIdle) && is_req(rw1);
    assign sel_valid = pend0 || pend1;
    // Pointer only matters when both are pending.
    assign sel_idx   = (pend0 && pend1) ? ptr_q : pend1;

    // The held memRw doubles as the latched op for the whole of BUSY.
    assign rd_done  = (state_q == StBusy) && (mem_rw_q == OP_RD) && memRdValid;
    assign wt_done  = (state_q == StBusy) && (mem_rw_q == OP_WT) && memWtDone;
    assign complete = rd_done || wt_done;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_bus_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (sel_valid),
        .enable(state_q == StBusy),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (sel_valid) state_d = StBusy;
            StBusy: begin
                if (complete) begin
                    state_d = StDone;
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d           = ptr_q;
        owner_d         = owner_q;
        grant_d         = grant_q;
        mem_rw_d        = mem_rw_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        data_to_cache_d = data_to_cache_q;
        addr_to_cache_d = addr_to_cache_q;
        read_en_d       = 2'b00;
        write_done_d    = 2'b00;
        bus_err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    owner_d    = sel_idx;
                    grant_d    = sel_idx ? 2'b10 : 2'b01;
                    mem_rw_d   = sel_idx ? rw1 : rw0;
                    mem_addr_d = sel_idx ? addr1 : addr0;
                    mem_data_d = sel_idx ? data1 : data0;
                end
            end
            StBusy: begin
                if (complete) begin
                    mem_rw_d        = OP_IDEL;
                    addr_to_cache_d = mem_addr_q;
                    if (rd_done) begin
                        data_to_cache_d    = memRdData;
                        read_en_d[owner_q] = 1'b1;
                    end else begin
                        write_done_d[owner_q] = 1'b1;
                    end
                end else if (expire) begin
                    bus_err_d = 1'b1;
                    mem_rw_d  = OP_IDEL;
                    grant_d   = 2'b00;
                    ptr_d     = ~owner_q;
                end
            end
            StDone: begin
                grant_d = 2'b00;
                ptr_d   = ~owner_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q           <= 1'b0;
            owner_q         <= 1'b0;
            grant_q         <= 2'b00;
            mem_rw_q        <= OP_IDEL;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            data_to_cache_q <= '0;
            addr_to_cache_q <= '0;
            read_en_q       <= 2'b00;
            write_done_q    <= 2'b00;
            bus_err_q       <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            owner_q         <= owner_d;
            grant_q         <= grant_d;
            mem_rw_q        <= mem_rw_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            data_to_cache_q <= data_to_cache_d;
            addr_to_cache_q <= addr_to_cache_d;
            read_en_q       <= read_en_d;
            write_done_q    <= write_done_d;
            bus_err_q       <= bus_err_d;
        end
    end

    assign readEn0     = read_en_q[0];
    assign readEn1     = read_en_q[1];
    assign writeDone0  = write_done_q[0];
    assign writeDone1  = write_done_q[1];
    assign dataToCache = data_to_cache_q;
    assign addrToCache = addr_to_cache_q;
    assign memRw       = mem_rw_q;
    assign memAddr     = mem_addr_q;
    assign memData     = mem_data_q;
    assign grant       = grant_q;
    assign busErr      = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a default-TIMEOUT instance and a TIMEOUT=4 instance
// share stimulus; completion pulses are checked against a scoreboard queue.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        logic [4:0]  vec;   // {readEn0, readEn1, writeDone0, writeDone1, busErr}
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset, reset_to, sel_to;
    logic [1:0]  rw0, rw1;
    logic [15:0] addr0, addr1, data0, data1;
    logic [15:0] memRdData;
    logic        memRdValid, memWtDone;

    logic        rd0_a, rd1_a, wd0_a, wd1_a, err_a, rd0_b, rd1_b, wd0_b, wd1_b, err_b;
    logic [15:0] dtc_a, atc_a, maddr_a, mdata_a, dtc_b, atc_b, maddr_b, mdata_b;
    logic [1:0]  mrw_a, grant_a, mrw_b, grant_b;

    logic        m_rd0, m_rd1, m_wd0, m_wd1, m_err;
    logic [15:0] m_dtc, m_atc, m_mem_addr, m_mem_data;
    logic [1:0]  m_mem_rw, m_grant;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    mem_bus_arbiter u_dut (
        .clk(clk), .reset(reset), .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .readEn0(rd0_a), .readEn1(rd1_a),
        .writeDone0(wd0_a), .writeDone1(wd1_a), .dataToCache(dtc_a), .addrToCache(atc_a),
        .memRw(mrw_a), .memAddr(maddr_a), .memData(mdata_a), .memRdData(memRdData),
        .memRdValid(memRdValid), .memWtDone(memWtDone), .grant(grant_a), .busErr(err_a)
    );

    mem_bus_arbiter #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .reset(reset_to), .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .readEn0(rd0_b), .readEn1(rd1_b),
        .writeDone0(wd0_b), .writeDone1(wd1_b), .dataToCache(dtc_b), .addrToCache(atc_b),
        .memRw(mrw_b), .memAddr(maddr_b), .memData(mdata_b), .memRdData(memRdData),
        .memRdValid(memRdValid), .memWtDone(memWtDone), .grant(grant_b), .busErr(err_b)
    );

    assign m_rd0      = sel_to ? rd0_b : rd0_a;
    assign m_rd1      = sel_to ? rd1_b : rd1_a;
    assign m_wd0      = sel_to ? wd0_b : wd0_a;
    assign m_wd1      = sel_to ? wd1_b : wd1_a;
    assign m_err      = sel_to ? err_b : err_a;
    assign m_dtc      = sel_to ? dtc_b : dtc_a;
    assign m_atc      = sel_to ? atc_b : atc_a;
    assign m_mem_rw   = sel_to ? mrw_b : mrw_a;
    assign m_mem_addr = sel_to ? maddr_b : maddr_a;
    assign m_mem_data = sel_to ? mdata_b : mdata_a;
    assign m_grant    = sel_to ? grant_b : grant_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic is_rd, input logic [15:0] rdata);
        memRdValid = is_rd;
        memWtDone  = !is_rd;
        memRdData  = rdata;
        step();
        memRdValid = 1'b0;
        memWtDone  = 1'b0;
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected completion/abort.
    always @(negedge clk) begin : mon
        logic [4:0] vec;
        exp_t       e;
        vec = {m_rd0, m_rd1, m_wd0, m_wd1, m_err};
        if (vec != 5'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 16'(vec), 16'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 16'(vec), 16'(e.vec));
                if (e.vec != 5'b00001) check("addr_to_cache", m_atc, e.addr);
                if (e.vec[4] || e.vec[3]) check("data_to_cache", m_dtc, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1; reset_to = 1'b1; sel_to = 1'b0;
        rw0 = OP_IDEL; rw1 = OP_IDEL; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        memRdData = '0; memRdValid = 1'b0; memWtDone = 1'b0;
        step(); step();
        check("rst_grant", 16'(m_grant), 16'd0);
        check("rst_mem_rw", 16'(m_mem_rw), 16'(OP_IDEL));
        check("rst_mem_addr", m_mem_addr, 16'h0);
        check("rst_mem_data", m_mem_data, 16'h0);
        check("rst_dtc", m_dtc, 16'h0);
        check("rst_atc", m_atc, 16'h0);
        check("rst_pulses", 16'({m_rd0, m_rd1, m_wd0, m_wd1, m_err}), 16'd0);
        reset = 1'b0;

        // Single read, response three cycles after memRw=RD.
        rw0 = OP_RD; addr0 = 16'h0040;
        step();
        check("rd_grant", 16'(m_grant), 16'b01);
        check("rd_mem_rw", 16'(m_mem_rw), 16'(OP_RD));
        check("rd_mem_addr", m_mem_addr, 16'h0040);
        rw0 = OP_IDEL;
        step(); step(); step();
        sb.push_back('{5'b10000, 16'h0040, 16'hBEEF});
        respond(1'b1, 16'hBEEF);
        check("rd_done_mem_rw", 16'(m_mem_rw), 16'(OP_IDEL));
        check("rd_done_grant", 16'(m_grant), 16'b01);
        step();
        check("rd_idle_grant", 16'(m_grant), 16'd0);

        // Contention straight after reset: cache0, cache1, cache0, cache1.
        reset = 1'b1; step(); reset = 1'b0;
        rw0 = OP_WT; addr0 = 16'h0100; data0 = 16'h1111;
        rw1 = OP_RD; addr1 = 16'h0200;
        step();
        check("c1_grant", 16'(m_grant), 16'b01);
        check("c1_mem_rw", 16'(m_mem_rw), 16'(OP_WT));
        check("c1_mem_data", m_mem_data, 16'h1111);
        sb.push_back('{5'b00100, 16'h0100, 16'h0});
        respond(1'b0, 16'h0);
        step(); step();
        check("c2_grant", 16'(m_grant), 16'b10);
        check("c2_mem_addr", m_mem_addr, 16'h0200);
        sb.push_back('{5'b01000, 16'h0200, 16'h2222});
        respond(1'b1, 16'h2222);
        step(); step();
        check("c3_grant", 16'(m_grant), 16'b01);
        sb.push_back('{5'b00100, 16'h0100, 16'h0});
        respond(1'b0, 16'h0);
        step(); step();
        check("c4_grant", 16'(m_grant), 16'b10);
        sb.push_back('{5'b01000, 16'h0200, 16'h2323});
        respond(1'b1, 16'h2323);
        rw0 = OP_IDEL; rw1 = OP_IDEL;
        step();
        check("c_idle_grant", 16'(m_grant), 16'd0);

        // Cache1 write; a stray memRdValid is ignored, memWtDone five cycles later completes.
        rw1 = OP_WT; addr1 = 16'h0300; data1 = 16'h3333;
        step();
        check("mm_grant", 16'(m_grant), 16'b10);
        rw1 = OP_IDEL;
        respond(1'b1, 16'hDEAD);
        for (int i = 0; i < 4; i++) begin
            check("mm_hold_rw", 16'(m_mem_rw), 16'(OP_WT));
            check("mm_hold_addr", m_mem_addr, 16'h0300);
            step();
        end
        sb.push_back('{5'b00010, 16'h0300, 16'h0});
        respond(1'b0, 16'h0);
        step();
        check("mm_idle_grant", 16'(m_grant), 16'd0);

        // Request withdrawn one cycle into BUSY still completes.
        rw0 = OP_RD; addr0 = 16'h0050;
        step();
        check("wd_grant", 16'(m_grant), 16'b01);
        step();
        rw0 = OP_IDEL;
        step();
        sb.push_back('{5'b10000, 16'h0050, 16'h5555});
        respond(1'b1, 16'h5555);
        step();

        // Reset in the middle of a cache1 write aborts it silently.
        rw1 = OP_WT; addr1 = 16'h0400;
        step();
        check("rb_grant", 16'(m_grant), 16'b10);
        rw1 = OP_IDEL;
        step();
        reset = 1'b1; memWtDone = 1'b1;
        step();
        check("rb_mem_rw", 16'(m_mem_rw), 16'(OP_IDEL));
        check("rb_grant_clr", 16'(m_grant), 16'd0);
        reset = 1'b0; memWtDone = 1'b0;
        rw0 = OP_RD; addr0 = 16'h0500; rw1 = OP_RD; addr1 = 16'h0600;
        step();
        check("rb_after_grant", 16'(m_grant), 16'b01);
        rw0 = OP_IDEL; rw1 = OP_IDEL;
        sb.push_back('{5'b10000, 16'h0500, 16'h6666});
        respond(1'b1, 16'h6666);
        step();

        // Timeout instance (TIMEOUT=4); main instance parked in reset.
        reset = 1'b1; sel_to = 1'b1; reset_to = 1'b0;
        step();
        rw0 = OP_RD; addr0 = 16'h0070;
        step();
        check("to_grant", 16'(m_grant), 16'b01);
        rw1 = OP_RD; addr1 = 16'h0080;
        sb.push_back('{5'b00001, 16'h0, 16'h0});
        step(); step(); step();
        check("to_b4_err", 16'(m_err), 16'd0);
        check("to_b4_rw", 16'(m_mem_rw), 16'(OP_RD));
        step();
        check("to_err", 16'(m_err), 16'd1);
        check("to_mem_rw", 16'(m_mem_rw), 16'(OP_IDEL));
        check("to_grant_clr", 16'(m_grant), 16'd0);
        step();
        check("to_regrant_c1", 16'(m_grant), 16'b10);
        check("to_c1_addr", m_mem_addr, 16'h0080);
        sb.push_back('{5'b01000, 16'h0080, 16'h8888});
        respond(1'b1, 16'h8888);
        rw1 = OP_IDEL;
        step(); step();
        check("to_regrant_c0", 16'(m_grant), 16'b01);
        rw0 = OP_IDEL;
        step(); step(); step();
        // Response lands on the same cycle the watchdog fires: completion wins.
        sb.push_back('{5'b10000, 16'h0070, 16'h9999});
        respond(1'b1, 16'h9999);
        step();
        check("tie_err", 16'(m_err), 16'd0);
        check("tie_grant", 16'(m_grant), 16'd0);
        step();
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, address width.
REQ-002 SHALL have parameter WORDWIDTH, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles before abort (legal range 1..255).
REQ-004 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports rw0/rw1  in  2  per-cache op: RD=2'd0, WT=2'd1, IDEL=2'd2, 2'd3 treated as IDEL.
REQ-007 SHALL have ports addr0/addr1  in  ADDRWIDTH, and data0/data1  in  WORDWIDTH: per-cache request address and write data.
REQ-008 SHALL have ports readEn0/readEn1 and writeDone0/writeDone1  out  1  per-cache one-cycle completion pulses.
REQ-009 SHALL have ports dataToCache  out  WORDWIDTH, and addrToCache  out  ADDRWIDTH: broadcast read data and address of the completed transaction.
REQ-010 SHALL have ports memRw  out  2, memAddr  out  ADDRWIDTH, memData  out  WORDWIDTH: shared memory request.
REQ-011 SHALL have ports memRdData  in  WORDWIDTH, memRdValid  in  1, memWtDone  in  1: memory responses.
REQ-012 SHALL have ports grant  out  2 (one-hot owner, 0 when idle) and busErr  out  1 (one-cycle timeout pulse).

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; all outputs registered.
REQ-014 A requester SHALL be pending when its rw is RD or WT and the state is IDLE.
REQ-015 IDLE with pending requests SHALL select one: if exactly one is pending it wins; if both are pending, the round-robin pointer wins. The selected rw/addr/data SHALL be latched, grant set, and the state moved to BUSY.
REQ-016 The cycle after selection, memRw/memAddr/memData SHALL present the latched request and hold it unchanged for the whole of BUSY.
REQ-017 In BUSY, memRdValid SHALL complete an RD only, and memWtDone SHALL complete a WT only. A mismatched or out-of-state response SHALL be ignored.
REQ-018 On completion at edge M, state SHALL become DONE and memRw SHALL become IDEL. For exactly cycle M+1, the owner's readEn or writeDone SHALL be 1, and addrToCache SHALL equal the latched address.
REQ-019 For an RD completion, dataToCache SHALL equal memRdData captured at completion.
REQ-020 DONE SHALL last one cycle, then go to IDLE. grant SHALL clear on entering IDLE, and the pointer SHALL then point to the non-served requester.
REQ-021 Best-case sequence: request at N → memRw valid at N+1 → response at M → pulse at M+1 → next grant sampled at M+2.
REQ-022 A requester dropping rw during BUSY SHALL NOT cancel the transaction; the latched request completes.
REQ-023 A BUSY cycle counter SHALL reset on entering BUSY. If it reaches TIMEOUT with no valid response, the block SHALL:
  - pulse busErr for one cycle;
  - drive memRw to IDEL;
  - clear grant;
  - produce no completion pulse;
  - go to IDLE with the pointer toggled.
REQ-024 If a valid response arrives in the same cycle as the timeout, completion SHALL take priority and busErr SHALL stay 0.
REQ-025 At most one of readEn0/1 and writeDone0/1 SHALL be high in any cycle.

Reset
REQ-026 reset SHALL force, on the next edge:
  - state IDLE, pointer to cache0, counter 0;
  - grant 0, memRw IDEL, memAddr/memData/dataToCache/addrToCache 0;
  - all pulses and busErr 0.
REQ-027 Reset during BUSY or DONE SHALL abort the transaction with no completion pulse.

Structure
REQ-028 The RD/WT/IDEL encodings, ADDRWIDTH/WORDWIDTH defaults and arbiter state encoding SHALL live in a shared package used by the cache and this block.
REQ-029 The timeout counter SHALL be a sub-module bus_watchdog, with inputs clear/enable and a one-cycle expire output.

Verification
REQ-030 Single read: rw0=RD, addr0=16'h0040; memRdValid with memRdData=16'hBEEF three cycles after memRw=RD → readEn0=1 for one cycle, dataToCache=16'hBEEF, addrToCache=16'h0040, grant=0 afterwards.
REQ-031 Contention: rw0=WT and rw1=RD asserted in the same cycle after reset → cache0 is served first, then cache1. On re-contention, cache0 is served, then cache1 again (alternation).
REQ-032 Mismatched response: cache1 WT, memRdValid pulsed, then memWtDone five cycles later → only writeDone1 pulses, after memWtDone.
REQ-033 Timeout: TIMEOUT=4, cache0 RD, no response → busErr=1 in the cycle after the 4th BUSY cycle, no readEn0, memRw=IDEL. With rw0 held, cache0 is re-granted only after any pending cache1 request.
REQ-034 Reset mid-BUSY: reset high during a cache1 WT → next cycle memRw=IDEL, grant=0, no writeDone1. After release with both requesting, cache0 wins.
REQ-035 Withdrawn request: rw0 drops to IDEL one cycle into BUSY → transaction still completes with a readEn0 pulse.
